irrigation_zone_sequencer: RTL and testbench

//   Multi-zone successor of the single-zone irrigation permit. Gates irrigation on: sensors consistent,

---
 rtl/irrigation_zone_sequencer_pkg.sv | 22 ++
 rtl/irrigation_zone_timer.sv | 22 ++
 rtl/irrigation_zone_sequencer.sv | 137 +++++++++++++
 tb/tb_irrigation_zone_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_zone_sequencer_pkg.sv
// Shared types for the irrigation zone sequencer: FSM state and per-zone
// watering mode encodings, plus the round-robin zone advance helper.
package irrigation_zone_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_IRRIGATE = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  typedef enum logic {
    MODE_DRIPPER   = 1'b0,
    MODE_SPRINKLER = 1'b1
  } mode_t;

  function automatic int unsigned next_zone(input int unsigned zone, input int unsigned zones);
    return (zone == zones - 1) ? 0 : zone + 1;
  endfunction

endpackage

// File: rtl/irrigation_zone_timer.sv
// Loadable up-counter with a terminal-count compare; shared by the scan,
// irrigate and settle phases of the sequencer.
module irrigation_zone_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || load) count <= '0;
    else               count <= count + 1'b1;
  end

  assign done = (count == last);

endmodule

// File: rtl/irrigation_zone_sequencer.sv
// Round-robin multi-zone irrigation sequencer: scans for a dry zone, waters it
// with one valve until wet or timed out, then settles before the next zone.
module irrigation_zone_sequencer
  import irrigation_zone_sequencer_pkg::*;
#(
  parameter int ZONES         = 4,
  parameter int TIMER_WIDTH   = 8,
  parameter int MAX_ON_CYCLES = 200,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       water_sensor_conflicting,
  input  logic                       low_water_level,
  input  logic [ZONES-1:0]           earth_humidity,
  input  logic [ZONES-1:0]           sprinkler_mode,
  output logic [ZONES-1:0]           valve_dripper,
  output logic [ZONES-1:0]           valve_sprinkler,
  output logic [$clog2(ZONES)-1:0]   active_zone,
  output logic                       busy,
  output logic                       timeout,
  output logic                       fault
);

  localparam int ZW = $clog2(ZONES);

  state_t                 state_q, state_d;
  mode_t                  mode_q, mode_d;
  logic [ZW-1:0]          ptr_q, ptr_d, ptr_inc;
  logic [TIMER_WIDTH-1:0] timer_last, timer_count;
  logic                   timer_load, timer_done;
  logic                   wet, timeout_d;
  logic [ZONES-1:0]       sel, drip_d, spr_d;

  assign wet     = earth_humidity[ptr_q];
  assign ptr_inc = ZW'(next_zone(32'(ptr_q), ZONES));

  irrigation_zone_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .last  (timer_last),
    .count (timer_count),
    .done  (timer_done)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mode_d    = mode_q;
    timeout_d = 1'b0;

    if (water_sensor_conflicting) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (!enable) state_d = ST_IDLE;
    end else if (!enable || !low_water_level) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SCAN;
        ST_SCAN: begin
          if (!wet) begin
            state_d = ST_IRRIGATE;
            mode_d  = mode_t'(sprinkler_mode[ptr_q]);
          end else begin
            // The last wet zone of a full turn wraps the pointer back to its start.
            ptr_d = ptr_inc;
            if (timer_done) state_d = ST_IDLE;
          end
        end
        ST_IRRIGATE: begin
          if (wet) begin
            state_d = ST_SETTLE;
          end else if (timer_done) begin
            state_d   = ST_SETTLE;
            timeout_d = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (timer_done) begin
            state_d = ST_SCAN;
            ptr_d   = ptr_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_SCAN:     timer_last = TIMER_WIDTH'(ZONES - 1);
      ST_IRRIGATE: timer_last = TIMER_WIDTH'(MAX_ON_CYCLES - 1);
      default:     timer_last = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    endcase
    timer_load = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FAULT);
  end

  // Valves are decoded from the next state so they switch on the same edge as the FSM.
  always_comb begin
    sel    = {{(ZONES-1){1'b0}}, 1'b1} << ptr_d;
    drip_d = '0;
    spr_d  = '0;
    if (state_d == ST_IRRIGATE) begin
      if (mode_d == MODE_SPRINKLER) spr_d  = sel;
      else                          drip_d = sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      mode_q          <= MODE_DRIPPER;
      ptr_q           <= '0;
      valve_dripper   <= '0;
      valve_sprinkler <= '0;
      busy            <= 1'b0;
      timeout         <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      ptr_q           <= ptr_d;
      valve_dripper   <= drip_d;
      valve_sprinkler <= spr_d;
      busy            <= (state_d == ST_SCAN) || (state_d == ST_IRRIGATE) || (state_d == ST_SETTLE);
      timeout         <= timeout_d;
      fault           <= (state_d == ST_FAULT);
    end
  end

  assign active_zone = ptr_q;

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// Directed and random bench for irrigation_zone_sequencer (4 zones, 8 on-cycles, 3 settle cycles).
module tb_irrigation_zone_sequencer;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       water_sensor_conflicting;
  logic       low_water_level;
  logic [3:0] earth_humidity;
  logic [3:0] sprinkler_mode;
  logic [3:0] valve_dripper;
  logic [3:0] valve_sprinkler;
  logic [1:0] active_zone;
  logic       busy;
  logic       timeout;
  logic       fault;

  irrigation_zone_sequencer #(
    .ZONES         (4),
    .TIMER_WIDTH   (8),
    .MAX_ON_CYCLES (8),
    .SETTLE_CYCLES (3)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .enable                   (enable),
    .water_sensor_conflicting (water_sensor_conflicting),
    .low_water_level          (low_water_level),
    .earth_humidity           (earth_humidity),
    .sprinkler_mode           (sprinkler_mode),
    .valve_dripper            (valve_dripper),
    .valve_sprinkler          (valve_sprinkler),
    .active_zone              (active_zone),
    .busy                     (busy),
    .timeout                  (timeout),
    .fault                    (fault)
  );

  typedef struct packed {
    logic [1:0] zone;
    logic       spr;
    logic [7:0] len;
    logic       to;
  } visit_t;

  visit_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  logic   sb_on  = 1'b1;
  logic   permit_at_edge = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) permit_at_edge <= !water_sensor_conflicting && low_water_level;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Packed as {dripper, sprinkler, zone, busy, timeout, fault}.
  task automatic expect_out(input string name, input logic [3:0] drip, input logic [3:0] spr,
                            input logic [1:0] zone, input logic bsy, input logic to, input logic flt);
    check(name, 32'({valve_dripper, valve_sprinkler, active_zone, busy, timeout, fault}),
          32'({drip, spr, zone, bsy, to, flt}));
  endtask

  task automatic push_visit(input logic [1:0] zone, input logic spr, input logic [7:0] len, input logic to);
    visit_t v;
    v.zone = zone; v.spr = spr; v.len = len; v.to = to;
    exp_q.push_back(v);
  endtask

  // Monitor: per-cycle invariants plus a scoreboard of completed valve visits.
  initial begin
    logic       in_visit = 1'b0;
    logic [1:0] cur_zone = '0;
    logic       cur_spr  = 1'b0;
    logic [7:0] cur_len  = '0;
    logic [3:0] v;
    int         pop;
    visit_t     e, a;
    forever begin
      @(negedge clock);
      v   = valve_dripper | valve_sprinkler;
      pop = $countones(v);
      check("valve_onehot", 32'({pop <= 1, (valve_dripper & valve_sprinkler) == 4'b0}), 32'b11);
      if (v != 4'b0) begin
        check("valve_needs_permit", 32'(permit_at_edge), 32'd1);
        if (!in_visit) begin
          in_visit = 1'b1;
          cur_len  = 8'd1;
          cur_spr  = |valve_sprinkler;
          for (int i = 0; i < 4; i++) if (v[i]) cur_zone = 2'(i);
        end else begin
          cur_len = cur_len + 8'd1;
        end
      end else if (in_visit) begin
        in_visit = 1'b0;
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            check("unexpected_visit", 32'(cur_zone), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            a.zone = cur_zone; a.spr = cur_spr; a.len = cur_len; a.to = timeout;
            check("visit{zone,spr,len,timeout}", 32'(a), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; water_sensor_conflicting = 1'b0;
    low_water_level = 1'b0; earth_humidity = '0; sprinkler_mode = '0;
    repeat (2) step();
    expect_out("reset_state", 4'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Zones 0,1 wet, zone 2 dry in dripper mode; zone 2 wets after 4 on-cycles.
    reset = 1'b0; enable = 1'b1; low_water_level = 1'b1; earth_humidity = 4'b1011;
    push_visit(2'd2, 1'b0, 8'd4, 1'b0);
    step(); expect_out("t1_scan0", 4'b0, 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t1_scan1", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t1_scan2", 4'b0, 4'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); expect_out("t1_drip_on", 4'b0100, 4'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    end
    earth_humidity = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("t1_settle", 4'b0, 4'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    end
    step(); expect_out("t1_resume_z3", 4'b0, 4'b0, 2'd3, 1'b1, 1'b0, 1'b0);

    // All wet: full turn 3,0,1,2 then one IDLE cycle, pointer back at 3.
    step(); expect_out("t3_scan_z0", 4'b0, 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t3_scan_z1", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t3_scan_z2", 4'b0, 4'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t3_idle", 4'b0, 4'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    step(); expect_out("t3_rearm", 4'b0, 4'b0, 2'd3, 1'b1, 1'b0, 1'b0);

    // Zone 0 dry forever in sprinkler mode: 8-cycle visit ending in timeout.
    earth_humidity = 4'b1110; sprinkler_mode = 4'b0001;
    push_visit(2'd0, 1'b1, 8'd8, 1'b1);
    step(); expect_out("t2_scan_z0", 4'b0, 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(); expect_out("t2_spr_on", 4'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
      if (i == 3) sprinkler_mode = 4'b0000;
    end
    step(); expect_out("t2_timeout", 4'b0, 4'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    step(); expect_out("t2_settle", 4'b0, 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t2_settle", 4'b0, 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t2_next_z1", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    step(); expect_out("t2_disable", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Conflict mid-irrigate latches fault until conflict clears and enable drops.
    earth_humidity = 4'b1101; enable = 1'b1;
    push_visit(2'd1, 1'b0, 8'd2, 1'b0);
    step(); expect_out("t4_scan", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t4_drip", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t4_drip", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    water_sensor_conflicting = 1'b1;
    step(); expect_out("t4_fault", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    step(); expect_out("t4_fault_hold", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    water_sensor_conflicting = 1'b0;
    step(); expect_out("t4_fault_enabled", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    step(); expect_out("t4_rearm_idle", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Supply drops mid-irrigate, then returns: re-scan from the same zone.
    enable = 1'b1;
    push_visit(2'd1, 1'b0, 8'd2, 1'b0);
    push_visit(2'd1, 1'b0, 8'd2, 1'b0);
    step(); expect_out("t5_scan", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t5_drip", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t5_drip", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    low_water_level = 1'b0;
    step(); expect_out("t5_low_idle", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step(); expect_out("t5_low_hold", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    low_water_level = 1'b1;
    step(); expect_out("t5_rescan", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t5_drip2", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t5_drip2", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    earth_humidity = 4'b1111;
    step(); expect_out("t5_wet_settle", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    step(); expect_out("t5_idle", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Reset mid-irrigate drops the valve and restarts the pointer at zone 0.
    earth_humidity = 4'b1101; enable = 1'b1;
    push_visit(2'd1, 1'b0, 8'd2, 1'b0);
    push_visit(2'd1, 1'b0, 8'd1, 1'b0);
    step(); expect_out("t6_scan", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t6_drip", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t6_drip", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(); expect_out("t6_reset", 4'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(); expect_out("t6_scan_z0", 4'b0, 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t6_scan_z1", 4'b0, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(); expect_out("t6_drip", 4'b0010, 4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    step(); expect_out("t6_idle", 4'b0, 4'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Random phase: only the per-cycle invariants are checked.
    sb_on = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset                    = ($urandom_range(0, 199) == 0);
      enable                   = ($urandom_range(0, 15) != 0);
      water_sensor_conflicting = ($urandom_range(0, 31) == 0);
      low_water_level          = ($urandom_range(0, 7) != 0);
      earth_humidity           = 4'($urandom);
      sprinkler_mode           = 4'($urandom);
      step();
    end

    reset = 1'b1;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
